// File: rtl/wb_vmon_pkg.sv
// Shared definitions for the vmon mailbox: register offsets, STATUS layout and FSM states.
package wb_vmon_pkg;

  localparam logic [1:0] DATA_OFF   = 2'd0;
  localparam logic [1:0] STATUS_OFF = 2'd1;

  localparam int ST_H2S_NONEMPTY = 0;
  localparam int ST_S2H_FULL     = 1;
  localparam int ST_H2S_CNT_LSB  = 8;
  localparam int ST_H2S_CNT_W    = 8;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    RESP       = 2'd1,
    WAIT_SPACE = 2'd2
  } vmon_state_e;

  function automatic logic [31:0] status_word(input logic h2s_nonempty,
                                              input logic s2h_full,
                                              input logic [ST_H2S_CNT_W-1:0] h2s_cnt);
    logic [31:0] w;
    w = '0;
    w[ST_H2S_NONEMPTY] = h2s_nonempty;
    w[ST_S2H_FULL] = s2h_full;
    w[ST_H2S_CNT_LSB +: ST_H2S_CNT_W] = h2s_cnt;
    return w;
  endfunction

endpackage

// File: rtl/wb_vmon_fifo.sv
// Synchronous first-word-fall-through FIFO; push and pop may coincide at any occupancy.
module wb_vmon_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot the push lands in.
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr_reg];
  assign count   = count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_reg + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= din;
  end

endmodule

// File: rtl/wb_vmon_mailbox.sv
// Wishbone responder for the vmon window: DATA writes feed the s2h stream, DATA reads drain h2s.
module wb_vmon_mailbox
  import wb_vmon_pkg::*;
#(
  parameter int                         WB_ADDR_WIDTH = 32,
  parameter int                         WB_DATA_WIDTH = 32,
  parameter logic [WB_ADDR_WIDTH-1:0]   ADDRESS       = 'h6000_1000,
  parameter int                         FIFO_DEPTH    = 4
) (
  input  logic                         clk_i,
  input  logic                         rstn_i,
  input  logic [WB_ADDR_WIDTH-1:0]     ADR,
  input  logic [WB_DATA_WIDTH-1:0]     DAT_W,
  output logic [WB_DATA_WIDTH-1:0]     DAT_R,
  input  logic                         CYC,
  input  logic                         STB,
  input  logic                         WE,
  input  logic [WB_DATA_WIDTH/8-1:0]   SEL,
  output logic                         ACK,
  output logic                         ERR,
  output logic [WB_DATA_WIDTH-1:0]     s2h_dat,
  output logic                         s2h_valid,
  input  logic                         s2h_ready,
  input  logic [WB_DATA_WIDTH-1:0]     h2s_dat,
  input  logic                         h2s_valid,
  output logic                         h2s_ready
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  vmon_state_e               state_reg;
  logic                      ack_reg;
  logic                      err_reg;
  logic [WB_DATA_WIDTH-1:0]  dat_r_reg;
  logic [WB_DATA_WIDTH-1:0]  wdata_reg;

  logic                      sel_hit;
  logic [1:0]                offset;
  logic [WB_DATA_WIDTH-1:0]  wdata_masked;
  logic                      s2h_full;
  logic                      s2h_empty;
  logic [CW-1:0]             s2h_count;
  logic                      s2h_room;
  logic                      s2h_push;
  logic [WB_DATA_WIDTH-1:0]  s2h_din;
  logic                      h2s_full;
  logic                      h2s_empty;
  logic [CW-1:0]             h2s_count;
  logic [WB_DATA_WIDTH-1:0]  h2s_head;
  logic                      h2s_pop;
  logic                      unused_bits;

  assign sel_hit  = CYC & STB & (ADR[WB_ADDR_WIDTH-1:4] == ADDRESS[WB_ADDR_WIDTH-1:4]);
  assign offset   = ADR[3:2];
  assign s2h_room = ~s2h_full | (s2h_valid & s2h_ready);

  generate
    for (genvar gi = 0; gi < WB_DATA_WIDTH / 8; gi++) begin : g_sel_mask
      assign wdata_masked[gi*8 +: 8] = SEL[gi] ? DAT_W[gi*8 +: 8] : 8'h00;
    end
  endgenerate

  // Push/pop fire on the same edge that registers ACK.
  always_comb begin
    s2h_push = 1'b0;
    h2s_pop  = 1'b0;
    s2h_din  = wdata_masked;
    case (state_reg)
      IDLE: begin
        if (sel_hit && offset == DATA_OFF) begin
          if (WE) s2h_push = s2h_room;
          else    h2s_pop  = 1'b1;
        end
      end
      WAIT_SPACE: begin
        s2h_din  = wdata_reg;
        s2h_push = CYC & s2h_room;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_reg <= IDLE;
      ack_reg   <= 1'b0;
      err_reg   <= 1'b0;
      dat_r_reg <= '0;
      wdata_reg <= '0;
    end else begin
      ack_reg <= 1'b0;
      err_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (sel_hit) begin
            dat_r_reg <= '0;
            state_reg <= RESP;
            case (offset)
              DATA_OFF: begin
                if (!WE) begin
                  ack_reg   <= 1'b1;
                  dat_r_reg <= h2s_empty ? '0 : h2s_head;
                end else if (s2h_room) begin
                  ack_reg <= 1'b1;
                end else begin
                  wdata_reg <= wdata_masked;
                  state_reg <= WAIT_SPACE;
                end
              end
              STATUS_OFF: begin
                ack_reg <= 1'b1;
                if (!WE) dat_r_reg <= status_word(~h2s_empty, s2h_full, ST_H2S_CNT_W'(h2s_count));
              end
              default: err_reg <= 1'b1;
            endcase
          end
        end
        RESP: state_reg <= IDLE;
        WAIT_SPACE: begin
          if (!CYC) begin
            state_reg <= IDLE;
          end else if (s2h_room) begin
            ack_reg   <= 1'b1;
            state_reg <= RESP;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  wb_vmon_fifo #(.WIDTH(WB_DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_s2h_fifo (
    .clk   (clk_i),
    .rst_n (rstn_i),
    .push  (s2h_push),
    .din   (s2h_din),
    .pop   (s2h_ready),
    .dout  (s2h_dat),
    .full  (s2h_full),
    .empty (s2h_empty),
    .count (s2h_count)
  );

  wb_vmon_fifo #(.WIDTH(WB_DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_h2s_fifo (
    .clk   (clk_i),
    .rst_n (rstn_i),
    .push  (h2s_valid & h2s_ready),
    .din   (h2s_dat),
    .pop   (h2s_pop),
    .dout  (h2s_head),
    .full  (h2s_full),
    .empty (h2s_empty),
    .count (h2s_count)
  );

  assign s2h_valid   = ~s2h_empty;
  assign h2s_ready   = ~h2s_full;
  assign ACK         = ack_reg;
  assign ERR         = err_reg;
  assign DAT_R       = dat_r_reg;
  assign unused_bits = ^{ADR[1:0], s2h_count};

endmodule

// File: tb/tb_wb_vmon_mailbox.sv
// Directed bench for wb_vmon_mailbox: bus accesses, stream handshakes, stall, abort and reset paths.
module tb_wb_vmon_mailbox;

  logic        clk_i = 1'b0;
  logic        rstn_i = 1'b0;
  logic [31:0] ADR = '0;
  logic [31:0] DAT_W = '0;
  logic [31:0] DAT_R;
  logic        CYC = 1'b0;
  logic        STB = 1'b0;
  logic        WE = 1'b0;
  logic [3:0]  SEL = 4'hF;
  logic        ACK;
  logic        ERR;
  logic [31:0] s2h_dat;
  logic        s2h_valid;
  logic        s2h_ready = 1'b0;
  logic [31:0] h2s_dat = '0;
  logic        h2s_valid = 1'b0;
  logic        h2s_ready;

  int total = 0;
  int bad = 0;

  localparam logic [31:0] A_DATA   = 32'h6000_1000;
  localparam logic [31:0] A_STATUS = 32'h6000_1004;

  wb_vmon_mailbox dut (
    .clk_i     (clk_i),
    .rstn_i    (rstn_i),
    .ADR       (ADR),
    .DAT_W     (DAT_W),
    .DAT_R     (DAT_R),
    .CYC       (CYC),
    .STB       (STB),
    .WE        (WE),
    .SEL       (SEL),
    .ACK       (ACK),
    .ERR       (ERR),
    .s2h_dat   (s2h_dat),
    .s2h_valid (s2h_valid),
    .s2h_ready (s2h_ready),
    .h2s_dat   (h2s_dat),
    .h2s_valid (h2s_valid),
    .h2s_ready (h2s_ready)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One Wishbone access, bounded to 8 cycles; returns response flags, read data and latency.
  task automatic bus(input logic [31:0] a, input logic [31:0] d, input logic we, input logic [3:0] sel,
                     output logic ack, output logic err, output logic [31:0] rd, output int lat);
    ADR = a; DAT_W = d; WE = we; SEL = sel; CYC = 1'b1; STB = 1'b1;
    ack = 1'b0; err = 1'b0; rd = '0; lat = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk_i); #1;
      if (ACK || ERR) begin
        ack = ACK; err = ERR; rd = DAT_R; lat = i + 1;
        break;
      end
    end
    CYC = 1'b0; STB = 1'b0; WE = 1'b0;
    $display("txn adr=%08h we=%0d sel=%h wdat=%08h ack=%0d err=%0d rdat=%08h lat=%0d",
             a, we, sel, d, ack, err, rd, lat);
    if (ack || err) begin
      @(posedge clk_i); #1;
      check("resp_single_cycle", {30'd0, ACK, ERR}, 32'd0);
    end
  endtask

  task automatic s2h_pop_check(input string tag, input logic [31:0] exp);
    check({tag, "_valid"}, {31'd0, s2h_valid}, 32'd1);
    check({tag, "_dat"}, s2h_dat, exp);
    s2h_ready = 1'b1;
    @(posedge clk_i); #1;
    s2h_ready = 1'b0;
  endtask

  task automatic h2s_push(input logic [31:0] d);
    h2s_dat = d; h2s_valid = 1'b1;
    @(posedge clk_i); #1;
    h2s_valid = 1'b0;
  endtask

  initial begin
    logic        ack, err;
    logic [31:0] rd;
    int          lat;
    logic        seen;
    int          pops;

    repeat (3) @(posedge clk_i);
    #1;
    check("rst_ack", {31'd0, ACK}, 32'd0);
    check("rst_err", {31'd0, ERR}, 32'd0);
    check("rst_dat_r", DAT_R, 32'd0);
    check("rst_s2h_valid", {31'd0, s2h_valid}, 32'd0);
    check("rst_h2s_ready", {31'd0, h2s_ready}, 32'd1);
    rstn_i = 1'b1;
    @(posedge clk_i); #1;

    // Basic write into s2h
    bus(A_DATA, 32'hDEADBEEF, 1'b1, 4'hF, ack, err, rd, lat);
    check("wr1_ack", {31'd0, ack}, 32'd1);
    check("wr1_lat", lat, 32'd1);
    s2h_pop_check("wr1_s2h", 32'hDEADBEEF);
    check("wr1_drained", {31'd0, s2h_valid}, 32'd0);

    // Byte-select masking
    bus(A_DATA, 32'hAABBCCDD, 1'b1, 4'b0001, ack, err, rd, lat);
    check("sel_ack", {31'd0, ack}, 32'd1);
    s2h_pop_check("sel_s2h", 32'h000000DD);

    // Fill s2h, then stall
    for (int i = 1; i <= 4; i++) begin
      bus(A_DATA, 32'h1111_1111 * i, 1'b1, 4'hF, ack, err, rd, lat);
      check("fill_ack", {31'd0, ack}, 32'd1);
    end
    bus(A_STATUS, 32'h0, 1'b0, 4'hF, ack, err, rd, lat);
    check("status_full", rd, 32'h0000_0002);

    ADR = A_DATA; DAT_W = 32'h5555_5555; WE = 1'b1; SEL = 4'hF; CYC = 1'b1; STB = 1'b1;
    seen = 1'b0;
    repeat (3) begin
      @(posedge clk_i); #1;
      seen = seen | ACK | ERR;
    end
    check("stall_no_ack", {31'd0, seen}, 32'd0);
    s2h_ready = 1'b1;
    @(posedge clk_i); #1;
    s2h_ready = 1'b0;
    check("stall_release_ack", {31'd0, ACK}, 32'd1);
    $display("txn adr=%08h we=1 wdat=55555555 stalled ack=%0d", A_DATA, ACK);
    CYC = 1'b0; STB = 1'b0; WE = 1'b0;
    @(posedge clk_i); #1;
    s2h_pop_check("order2", 32'h2222_2222);
    s2h_pop_check("order3", 32'h3333_3333);
    s2h_pop_check("order4", 32'h4444_4444);
    s2h_pop_check("order5", 32'h5555_5555);
    check("order_empty", {31'd0, s2h_valid}, 32'd0);

    // h2s path
    h2s_push(32'h1234_5678);
    bus(A_STATUS, 32'h0, 1'b0, 4'hF, ack, err, rd, lat);
    check("status_h2s1", rd, 32'h0000_0101);
    bus(A_DATA, 32'h0, 1'b0, 4'hF, ack, err, rd, lat);
    check("h2s_read_ack", {31'd0, ack}, 32'd1);
    check("h2s_read_dat", rd, 32'h1234_5678);
    bus(A_STATUS, 32'h0, 1'b0, 4'hF, ack, err, rd, lat);
    check("status_empty", rd, 32'h0000_0000);

    // Empty read, error window, unselected address
    bus(A_DATA, 32'h0, 1'b0, 4'hF, ack, err, rd, lat);
    check("empty_read_ack", {31'd0, ack}, 32'd1);
    check("empty_read_dat", rd, 32'h0);
    bus(32'h6000_1008, 32'hCAFE_F00D, 1'b1, 4'hF, ack, err, rd, lat);
    check("err_win_ack", {31'd0, ack}, 32'd0);
    check("err_win_err", {31'd0, err}, 32'd1);
    bus(32'h6000_100C, 32'h0, 1'b0, 4'hF, ack, err, rd, lat);
    check("err_win3_err", {31'd0, err}, 32'd1);
    check("err_no_push", {31'd0, s2h_valid}, 32'd0);
    bus(32'h6000_2000, 32'h0, 1'b1, 4'hF, ack, err, rd, lat);
    check("unsel_no_resp", {30'd0, ack, err}, 32'd0);
    check("unsel_no_push", {31'd0, s2h_valid}, 32'd0);
    bus(A_STATUS, 32'hFFFF_FFFF, 1'b1, 4'hF, ack, err, rd, lat);
    check("status_wr_ack", {31'd0, ack}, 32'd1);
    check("status_wr_nopush", {31'd0, s2h_valid}, 32'd0);

    // Abort while stalled on full s2h
    for (int i = 0; i < 4; i++) begin
      bus(A_DATA, 32'hA000_0000 + i, 1'b1, 4'hF, ack, err, rd, lat);
    end
    ADR = A_DATA; DAT_W = 32'hBAD0_BAD0; WE = 1'b1; SEL = 4'hF; CYC = 1'b1; STB = 1'b1;
    seen = 1'b0;
    repeat (3) begin
      @(posedge clk_i); #1;
      seen = seen | ACK | ERR;
    end
    CYC = 1'b0; STB = 1'b0; WE = 1'b0;
    repeat (2) begin
      @(posedge clk_i); #1;
      seen = seen | ACK | ERR;
    end
    $display("txn adr=%08h we=1 wdat=bad0bad0 aborted resp_seen=%0d", A_DATA, seen);
    check("abort_no_ack", {31'd0, seen}, 32'd0);
    check("abort_first", s2h_dat, 32'hA000_0000);
    pops = 0;
    for (int i = 0; i < 10 && s2h_valid; i++) begin
      s2h_ready = 1'b1;
      @(posedge clk_i); #1;
      pops++;
    end
    s2h_ready = 1'b0;
    check("abort_count", pops, 32'd4);

    // h2s full boundary and no-overwrite
    for (int i = 0; i < 4; i++) h2s_push(32'hB000_0000 + i);
    check("h2s_full_ready", {31'd0, h2s_ready}, 32'd0);
    h2s_push(32'hDEAD_0000);
    bus(A_STATUS, 32'h0, 1'b0, 4'hF, ack, err, rd, lat);
    check("status_h2s_full", rd, 32'h0000_0401);
    bus(A_DATA, 32'h0, 1'b0, 4'hF, ack, err, rd, lat);
    check("h2s_no_overwrite", rd, 32'hB000_0000);
    h2s_push(32'hB000_0004);
    check("h2s_refull", {31'd0, h2s_ready}, 32'd0);

    // Reset during RESP
    ADR = A_DATA; DAT_W = 32'h7777_7777; WE = 1'b1; SEL = 4'hF; CYC = 1'b1; STB = 1'b1;
    @(posedge clk_i); #1;
    check("pre_rst_ack", {31'd0, ACK}, 32'd1);
    #2 rstn_i = 1'b0;
    #1;
    check("midrst_ack", {31'd0, ACK}, 32'd0);
    check("midrst_s2h_valid", {31'd0, s2h_valid}, 32'd0);
    check("midrst_h2s_ready", {31'd0, h2s_ready}, 32'd1);
    CYC = 1'b0; STB = 1'b0; WE = 1'b0;
    $display("txn adr=%08h we=1 wdat=77777777 reset mid-response", A_DATA);
    @(negedge clk_i);
    rstn_i = 1'b1;
    @(posedge clk_i); #1;
    bus(A_STATUS, 32'h0, 1'b0, 4'hF, ack, err, rd, lat);
    check("post_rst_status", rd, 32'h0000_0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
